// File: rtl/inject_queue.sv
// inject_queue: in-order packet FIFO in front of one router. Holds the head
// packet until its scheduled cycle is due and its VC has a free slot, then
// issues it to the router as a one-clk OP_INJECT.
//
// state | meaning
// IDLE  | FIFO empty, nothing to inject
// WAIT  | head present, waiting for a due inject window with a free VC
// ISSUE | OP_INJECT is on the router inputs for this one clk
module inject_queue #(
  parameter int QDEPTH    = 8,
  parameter int CYC_W     = 16,
  parameter int DST_W     = 4,
  parameter int VC_BIT    = 2,
  parameter int PAY_W     = 26,
  parameter int OP_W      = 3,
  parameter int OP_NOP    = 0,
  parameter int OP_INJECT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [CYC_W-1:0]              load_cycle,
  input  logic [DST_W-1:0]              load_dst,
  input  logic [VC_BIT-1:0]             load_vc,
  input  logic [PAY_W-1:0]              load_payload,
  input  logic                          load_last,
  input  logic [CYC_W-1:0]              in_cycle,
  input  logic                          phase_inject,
  input  logic [(2**VC_BIT)-1:0]        can_inject,
  output logic [OP_W-1:0]               op,
  output logic [DST_W+VC_BIT+PAY_W-1:0] data,
  output logic [15:0]                   injected_count,
  output logic [15:0]                   stall_count,
  output logic                          done
);

  localparam int DATA_W = DST_W + VC_BIT + PAY_W;
  localparam int ENT_W  = CYC_W + DATA_W;
  localparam int PTR_W  = $clog2(QDEPTH);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(QDEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OP_W-1:0]  OP_NOP_V = OP_W'(OP_NOP);
  localparam logic [OP_W-1:0]  OP_INJ_V = OP_W'(OP_INJECT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ENT_W-1:0]    r_mem [QDEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W:0]      r_count;
  logic                r_rdy_en;
  logic                r_last_seen;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_data;
  logic [15:0]         r_inj_cnt;
  logic [15:0]         r_stall_cnt;
  logic                r_done;

  logic [ENT_W-1:0]    w_head;
  logic [CYC_W-1:0]    w_head_cyc;
  logic [VC_BIT-1:0]   w_head_vc;
  logic [CYC_W-1:0]    w_diff;
  logic                w_due;
  logic                w_vc_free;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_stall;

  // r_rdy_en holds load_ready low through reset and the edge that ends it
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign load_ready = r_rdy_en && !w_full;
  assign w_push     = load_valid && load_ready;

  assign w_head     = r_mem[r_rptr];
  assign w_head_cyc = w_head[ENT_W-1 -: CYC_W];
  assign w_head_vc  = w_head[PAY_W +: VC_BIT];
  assign w_diff     = in_cycle - w_head_cyc;
  assign w_due      = !w_diff[CYC_W-1];
  assign w_vc_free  = can_inject[w_head_vc];

  assign op             = r_op;
  assign data           = r_data;
  assign injected_count = r_inj_cnt;
  assign stall_count    = r_stall_cnt;
  assign done           = r_done;

  // Next state, pop and stall decisions for the inject window
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (phase_inject && w_due) begin
          if (w_vc_free) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = w_empty ? S_IDLE : S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FIFO pointers, occupancy and load enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; entries are only read once the count covers them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {load_cycle, load_dst, load_vc, load_payload};
  end

  // Router outputs, statistics and trace completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OP_NOP_V;
      r_data      <= '0;
      r_inj_cnt   <= '0;
      r_stall_cnt <= '0;
      r_last_seen <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_op <= w_pop ? OP_INJ_V : OP_NOP_V;
      if (w_pop) begin
        r_data    <= w_head[DATA_W-1:0];
        r_inj_cnt <= r_inj_cnt + 16'd1;
      end
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_push && load_last) r_last_seen <= 1'b1;
      // a new push drops done on its own acceptance edge
      r_done <= w_push ? 1'b0 : (r_last_seen && w_empty && r_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_inject_queue.sv
// Directed bench for inject_queue with a scoreboard of expected injections
// (payload plus the in_cycle of the strobe that must issue it).
module tb_inject_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_cycle = '0;
  logic [3:0]  load_dst = '0;
  logic [1:0]  load_vc = '0;
  logic [25:0] load_payload = '0;
  logic        load_last = 1'b0;
  logic [15:0] in_cycle = '0;
  logic        phase_inject = 1'b0;
  logic [3:0]  can_inject = '0;
  logic [2:0]  op;
  logic [31:0] data;
  logic [15:0] injected_count;
  logic [15:0] stall_count;
  logic        done;

  localparam logic [2:0] OPI = 3'd3;

  typedef struct {
    logic [31:0] d;
    logic [15:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_inj = 1'b0;

  inject_queue dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_cycle(load_cycle), .load_dst(load_dst), .load_vc(load_vc),
    .load_payload(load_payload), .load_last(load_last),
    .in_cycle(in_cycle), .phase_inject(phase_inject), .can_inject(can_inject),
    .op(op), .data(data),
    .injected_count(injected_count), .stall_count(stall_count), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [3:0] dst, input logic [1:0] vc,
                                     input logic [25:0] pay);
    return {dst, vc, pay};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_inj(input logic [31:0] d, input logic [15:0] cyc);
    exp_t e;
    e.d = d;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: every OP_INJECT must match the oldest expectation and last one clk
  always @(negedge clk) begin
    if (op === OPI) begin
      if (prev_inj) begin
        n_cmp++; n_bad++;
        $display("FAIL op_width: op=%0d on two consecutive clks, required one", op);
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_inject: data=%0h in_cycle=%0h, required none", data, in_cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (data !== e.d || in_cycle !== e.cyc) begin
          n_bad++;
          $display("FAIL inject: data=%0h at in_cycle=%0h, required data=%0h at in_cycle=%0h",
                   data, in_cycle, e.d, e.cyc);
        end
      end
    end
    prev_inj = (op === OPI);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_valid = 1'b0;
    phase_inject = 1'b0;
    clk1();
    clk1();
    rst_n = 1'b1;
    clk1();
  endtask

  task automatic load(input logic [15:0] cyc, input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_cycle = cyc;
    {load_dst, load_vc, load_payload} = d;
    load_last = last;
    clk1();
    load_valid = 1'b0;
    load_last = 1'b0;
    clk1();
  endtask

  task automatic strobe_start(input logic [15:0] cyc, input logic [3:0] can);
    in_cycle = cyc;
    can_inject = can;
    phase_inject = 1'b1;
    clk1();
    phase_inject = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] cyc, input logic [3:0] can);
    strobe_start(cyc, can);
    clk1();
    clk1();
  endtask

  initial begin
    // reset values
    clk1();
    clk1();
    chk("rst_op", op, 0);
    chk("rst_data", data, 0);
    chk("rst_inj", injected_count, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 0);
    rst_n = 1'b1;
    clk1();
    chk("ready_after_rst", load_ready, 1);

    // single packet, injected on the in_cycle=5 strobe
    load(16'd5, pk(4'd3, 2'd2, 26'hABC), 1'b0);
    expect_inj(pk(4'd3, 2'd2, 26'hABC), 16'd5);
    for (int c = 1; c <= 7; c++) strobe(16'(c), 4'hF);
    chk("t1_inj_count", injected_count, 1);
    chk("t1_data_hold", data, pk(4'd3, 2'd2, 26'hABC));
    chk("t1_op_idle", op, 0);

    // VC blocked for three windows
    do_reset();
    load(16'd5, pk(4'd3, 2'd2, 26'hABC), 1'b0);
    expect_inj(pk(4'd3, 2'd2, 26'hABC), 16'd8);
    strobe(16'd5, 4'hB);
    chk("t2_stall_1", stall_count, 1);
    strobe(16'd6, 4'hB);
    strobe(16'd7, 4'hB);
    strobe(16'd8, 4'hF);
    chk("t2_stall", stall_count, 3);
    chk("t2_inj_count", injected_count, 1);

    // fill, refuse a ninth, drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("t3_ready_before_push", load_ready, 1);
      load(16'h0100, pk(4'(i), 2'(i), 26'h1000 + 26'(i)), 1'b0);
      expect_inj(pk(4'(i), 2'(i), 26'h1000 + 26'(i)), 16'h0100 + 16'(i));
    end
    chk("t3_full_ready", load_ready, 0);
    load_valid = 1'b1;
    load_cycle = 16'h0100;
    {load_dst, load_vc, load_payload} = pk(4'hF, 2'd3, 26'h9999);
    clk1();
    load_valid = 1'b0;
    chk("t3_ninth_ready", load_ready, 0);
    strobe_start(16'h0100, 4'hF);
    chk("t3_ready_after_pop", load_ready, 1);
    clk1();
    clk1();
    for (int i = 1; i < 8; i++) strobe(16'h0100 + 16'(i), 4'hF);
    strobe(16'h0108, 4'hF);
    chk("t3_inj_count", injected_count, 8);

    // in_cycle wrap
    do_reset();
    load(16'hFFFE, pk(4'd1, 2'd1, 26'h111), 1'b0);
    expect_inj(pk(4'd1, 2'd1, 26'h111), 16'hFFFE);
    strobe(16'hFFFD, 4'hF);
    chk("t4_not_early", injected_count, 0);
    strobe(16'hFFFE, 4'hF);
    in_cycle = 16'hFFFF;
    load(16'h0001, pk(4'd2, 2'd3, 26'h222), 1'b0);
    expect_inj(pk(4'd2, 2'd3, 26'h222), 16'h0001);
    strobe(16'hFFFF, 4'hF);
    strobe(16'h0000, 4'hF);
    chk("t4_wrap_wait", injected_count, 1);
    strobe(16'h0001, 4'hF);
    chk("t4_inj_count", injected_count, 2);
    chk("t4_stall", stall_count, 0);

    // trace end and done
    do_reset();
    load(16'h0010, pk(4'd5, 2'd0, 26'h301), 1'b0);
    load(16'h0010, pk(4'd6, 2'd1, 26'h302), 1'b0);
    load(16'h0010, pk(4'd7, 2'd3, 26'h303), 1'b1);
    expect_inj(pk(4'd5, 2'd0, 26'h301), 16'h0010);
    expect_inj(pk(4'd6, 2'd1, 26'h302), 16'h0011);
    expect_inj(pk(4'd7, 2'd3, 26'h303), 16'h0012);
    chk("t5_done_early", done, 0);
    strobe(16'h0010, 4'hF);
    strobe(16'h0011, 4'hF);
    strobe_start(16'h0012, 4'hF);
    chk("t5_last_op", op, OPI);
    chk("t5_done_issue", done, 0);
    clk1();
    chk("t5_done_idle_edge", done, 0);
    clk1();
    chk("t5_done", done, 1);
    chk("t5_inj_count", injected_count, 3);
    load(16'h0020, pk(4'd8, 2'd2, 26'h404), 1'b0);
    chk("t5_done_cleared", done, 0);

    // reset in the OP_INJECT clk flushes the queue
    load(16'h0020, pk(4'd9, 2'd1, 26'h505), 1'b0);
    expect_inj(pk(4'd8, 2'd2, 26'h404), 16'h0020);
    strobe_start(16'h0020, 4'hF);
    chk("t6_op_before_rst", op, OPI);
    rst_n = 1'b0;
    clk1();
    chk("t6_op", op, 0);
    chk("t6_inj", injected_count, 0);
    chk("t6_stall", stall_count, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", load_ready, 0);
    rst_n = 1'b1;
    clk1();
    chk("t6_ready_after", load_ready, 1);
    strobe(16'h0020, 4'hF);
    strobe(16'h0021, 4'hF);
    chk("t6_flushed", injected_count, 0);
    chk("t6_done_after", done, 0);

    clk1();
    chk("missing_injects", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
